// File: rtl/cpuif_cmd_sequencer.sv
// cpuif_cmd_sequencer
// Buffered command master for a regblock passthrough CPU interface.
// Commands are queued in a small FIFO and issued one at a time. Regblock
// stalls are honoured, and each completion comes back on a valid/ready
// response port, including regblock error and timeout status.
module cpuif_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  arst_n,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_is_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [DATA_WIDTH-1:0] cmd_biten,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_is_wr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,

  output logic                  busy,

  output logic                  cpuif_req,
  output logic                  cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0] cpuif_addr,
  output logic [DATA_WIDTH-1:0] cpuif_wr_data,
  output logic [DATA_WIDTH-1:0] cpuif_wr_biten,
  input  logic                  cpuif_req_stall_wr,
  input  logic                  cpuif_req_stall_rd,
  input  logic                  cpuif_rd_ack,
  input  logic                  cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0] cpuif_rd_data,
  input  logic                  cpuif_wr_ack,
  input  logic                  cpuif_wr_err
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 1 + ADDR_WIDTH + 2 * DATA_WIDTH;
  localparam int unsigned TMO_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_RESP
  } state_t;

  state_t state;

  // Command FIFO
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Transaction tracking
  logic [TMO_W-1:0]      tmo_cnt;
  logic [TMO_W-1:0]      tmo_next;
  logic                  tmo_hit;
  logic                  stall_cur;
  logic                  ack_cur;
  logic                  err_cur;
  logic [DATA_WIDTH-1:0] rdata_cur;
  logic                  ack_take;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  // arst_n is folded in so cmd_ready is low throughout reset
  assign cmd_ready  = !fifo_full && arst_n;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign head       = mem[rd_ptr];
  assign busy       = !fifo_empty || (state != S_IDLE);

  // FIFO storage; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_is_wr, cmd_addr, cmd_wdata, cmd_biten};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Select the stall/ack/err/data matching the in-flight command type,
  // and evaluate the timeout and completion conditions
  always_comb begin
    stall_cur = cpuif_req_is_wr ? cpuif_req_stall_wr : cpuif_req_stall_rd;
    ack_cur   = cpuif_req_is_wr ? cpuif_wr_ack       : cpuif_rd_ack;
    err_cur   = cpuif_req_is_wr ? cpuif_wr_err       : cpuif_rd_err;
    rdata_cur = cpuif_req_is_wr ? '0                 : cpuif_rd_data;
    tmo_next  = tmo_cnt + TMO_W'(1);
    tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_next == TMO_W'(TIMEOUT_CYCLES));
    ack_take  = 1'b0;
    if (state == S_ISSUE) begin
      ack_take = !stall_cur && ack_cur;
    end else if (state == S_WAIT_ACK) begin
      ack_take = ack_cur;
    end
  end

  // Transaction FSM with registered request and response outputs
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state           <= S_IDLE;
      tmo_cnt         <= '0;
      cpuif_req       <= 1'b0;
      cpuif_req_is_wr <= 1'b0;
      cpuif_addr      <= '0;
      cpuif_wr_data   <= '0;
      cpuif_wr_biten  <= '0;
      rsp_valid       <= 1'b0;
      rsp_is_wr       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      rsp_timeout     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            {cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten} <= head;
            cpuif_req <= 1'b1;
            tmo_cnt   <= '0;
            state     <= S_ISSUE;
          end
        end

        // ISSUE and WAIT_ACK share completion and timeout handling; a real
        // ack in the same cycle as the timeout wins over the timeout
        S_ISSUE, S_WAIT_ACK: begin
          tmo_cnt <= tmo_next;
          if (ack_take) begin
            rsp_is_wr   <= cpuif_req_is_wr;
            rsp_rdata   <= rdata_cur;
            rsp_err     <= err_cur;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            cpuif_req   <= 1'b0;
            state       <= S_RESP;
          end else if (tmo_hit) begin
            rsp_is_wr   <= cpuif_req_is_wr;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            cpuif_req   <= 1'b0;
            state       <= S_RESP;
          end else if ((state == S_ISSUE) && !stall_cur) begin
            cpuif_req <= 1'b0;
            state     <= S_WAIT_ACK;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpuif_cmd_sequencer.sv
// Scoreboard bench for cpuif_cmd_sequencer: the stimulus process pushes the
// expected completion of every command, a monitor pops and compares on each
// response handshake, and a small regblock responder drives the acks.
`timescale 1ns/1ps
module tb_cpuif_cmd_sequencer;

  typedef logic [159:0] v_t;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cmd_valid, cmd_ready, cmd_is_wr;
  logic [31:0] cmd_addr, cmd_wdata, cmd_biten;
  logic        rsp_valid, rsp_ready, rsp_is_wr, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        cpuif_req, cpuif_req_is_wr;
  logic [31:0] cpuif_addr, cpuif_wr_data, cpuif_wr_biten;
  logic        cpuif_req_stall_wr, cpuif_req_stall_rd;
  logic        cpuif_rd_ack, cpuif_rd_err, cpuif_wr_ack, cpuif_wr_err;
  logic [31:0] cpuif_rd_data;

  rsp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ack_mode  = 1;
  int   ack_delay = 1;
  int   inject_req  = 0;
  int   inject_done = 0;

  always #5 clk = ~clk;

  cpuif_cmd_sequencer #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk               (clk),
    .arst_n            (arst_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_is_wr         (cmd_is_wr),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .cmd_biten         (cmd_biten),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_is_wr         (rsp_is_wr),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .rsp_timeout       (rsp_timeout),
    .busy              (busy),
    .cpuif_req         (cpuif_req),
    .cpuif_req_is_wr   (cpuif_req_is_wr),
    .cpuif_addr        (cpuif_addr),
    .cpuif_wr_data     (cpuif_wr_data),
    .cpuif_wr_biten    (cpuif_wr_biten),
    .cpuif_req_stall_wr(cpuif_req_stall_wr),
    .cpuif_req_stall_rd(cpuif_req_stall_rd),
    .cpuif_rd_ack      (cpuif_rd_ack),
    .cpuif_rd_err      (cpuif_rd_err),
    .cpuif_rd_data     (cpuif_rd_data),
    .cpuif_wr_ack      (cpuif_wr_ack),
    .cpuif_wr_err      (cpuif_wr_err)
  );

  function automatic v_t all_outs();
    return v_t'({cmd_ready, rsp_valid, rsp_is_wr, rsp_rdata, rsp_err, rsp_timeout, busy,
                 cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input v_t got, input v_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic exp_push(input logic w, input logic [31:0] d, input logic e, input logic t);
    rsp_t x;
    x.is_wr = w;
    x.rdata = d;
    x.err   = e;
    x.tmo   = t;
    sb.push_back(x);
  endtask

  // Offer one command and return #1 after the edge that accepts it
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] b);
    cmd_valid = 1'b1;
    cmd_is_wr = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_biten = b;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) break;
      tick();
    end
    check("cmd_accept", v_t'(cmd_ready), v_t'(1));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check(name, v_t'(done), v_t'(1));
  endtask

  task automatic wait_rsp(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(name, v_t'(seen), v_t'(1));
  endtask

  // Regblock read data map and error addresses
  task automatic drive_ack(input logic w, input logic [31:0] a);
    if (w) begin
      cpuif_wr_ack  = 1'b1;
      cpuif_wr_err  = (a == 32'h34);
      cpuif_rd_data = 32'hFFFF_FFFF;
    end else begin
      cpuif_rd_ack  = 1'b1;
      cpuif_rd_err  = (a == 32'h30);
      cpuif_rd_data = (a == 32'h10) ? 32'hDEAD_BEEF :
                      (a == 32'h30) ? 32'h0BAD_0030 : {16'hC0DE, a[15:0]};
    end
  endtask

  // Regblock responder: acks ack_delay cycles after acceptance, with the
  // opposite-type ack driven in the intervening cycles
  initial begin : responder
    logic        waiting;
    int          dly;
    logic        w_is_wr;
    logic [31:0] w_addr;
    waiting = 1'b0;
    dly     = 0;
    w_is_wr = 1'b0;
    w_addr  = '0;
    cpuif_rd_ack  = 1'b0;
    cpuif_wr_ack  = 1'b0;
    cpuif_rd_err  = 1'b0;
    cpuif_wr_err  = 1'b0;
    cpuif_rd_data = '0;
    forever begin
      @(posedge clk);
      #2;
      cpuif_rd_ack  = 1'b0;
      cpuif_wr_ack  = 1'b0;
      cpuif_rd_err  = 1'b0;
      cpuif_wr_err  = 1'b0;
      cpuif_rd_data = '0;
      if (!arst_n) begin
        waiting = 1'b0;
      end else if (inject_done != inject_req) begin
        cpuif_rd_ack  = 1'b1;
        cpuif_wr_ack  = 1'b1;
        cpuif_rd_data = 32'h1234_5678;
        inject_done++;
      end else if (waiting) begin
        if (dly > 1) begin
          dly--;
          if (w_is_wr) begin
            cpuif_rd_ack  = 1'b1;
            cpuif_rd_data = 32'hFFFF_FFFF;
          end else begin
            cpuif_wr_ack = 1'b1;
          end
        end else begin
          drive_ack(w_is_wr, w_addr);
          waiting = 1'b0;
        end
      end else if (ack_mode != 0 && cpuif_req &&
                   !(cpuif_req_is_wr ? cpuif_req_stall_wr : cpuif_req_stall_rd)) begin
        if (ack_delay == 0) begin
          drive_ack(cpuif_req_is_wr, cpuif_addr);
        end else begin
          waiting = 1'b1;
          dly     = ack_delay;
          w_is_wr = cpuif_req_is_wr;
          w_addr  = cpuif_addr;
        end
      end
    end
  end

  // Response monitor: compare every handshake against the scoreboard head
  initial begin : monitor
    rsp_t got;
    rsp_t exp;
    forever begin
      @(negedge clk);
      if (arst_n && rsp_valid && rsp_ready) begin
        got.is_wr = rsp_is_wr;
        got.rdata = rsp_rdata;
        got.err   = rsp_err;
        got.tmo   = rsp_timeout;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got %0h required no response", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL rsp_order: got wr=%0b rdata=%0h err=%0b tmo=%0b required wr=%0b rdata=%0h err=%0b tmo=%0b",
                     got.is_wr, got.rdata, got.err, got.tmo, exp.is_wr, exp.rdata, exp.err, exp.tmo);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    arst_n = 1'b0;
    cmd_valid = 1'b0; cmd_is_wr = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_biten = '0;
    rsp_ready = 1'b1;
    cpuif_req_stall_wr = 1'b0;
    cpuif_req_stall_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), v_t'(0));
    arst_n = 1'b1;
    tick();
    check("ready_after_reset", v_t'({cmd_ready, busy}), v_t'(2'b10));

    // Single read with latency checks
    exp_push(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    send(1'b0, 32'h10, 32'h0, 32'h0);
    check("rd_req_k", v_t'(cpuif_req), v_t'(0));
    tick();
    check("rd_req_k1", v_t'({cpuif_req, cpuif_req_is_wr, cpuif_addr}), v_t'({1'b1, 1'b0, 32'h10}));
    tick();
    check("rd_wait", v_t'({cpuif_req, rsp_valid}), v_t'(2'b00));
    tick();
    check("rd_rsp_lat", v_t'({rsp_valid, rsp_rdata, rsp_err}), v_t'({1'b1, 32'hDEAD_BEEF, 1'b0}));
    wait_idle("idle_read");

    // Stalled write, held fields, stray read ack while waiting
    ack_delay = 2;
    cpuif_req_stall_wr = 1'b1;
    exp_push(1'b1, 32'h0, 1'b0, 1'b0);
    send(1'b1, 32'h4, 32'h5A, 32'hFF);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("wr_hold", v_t'({cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten}),
            v_t'({1'b1, 1'b1, 32'h4, 32'h5A, 32'hFF}));
      if (i == 3) cpuif_req_stall_wr = 1'b0;
      tick();
    end
    check("wr_accepted", v_t'(cpuif_req), v_t'(0));
    wait_idle("idle_write");
    ack_delay = 1;

    // Regblock errors, then an ack in the accepting cycle
    exp_push(1'b0, 32'h0BAD_0030, 1'b1, 1'b0);
    send(1'b0, 32'h30, 32'h0, 32'h0);
    exp_push(1'b1, 32'h0, 1'b1, 1'b0);
    send(1'b1, 32'h34, 32'h1, 32'hF);
    wait_idle("idle_err");
    ack_delay = 0;
    exp_push(1'b0, 32'hC0DE_0020, 1'b0, 1'b0);
    send(1'b0, 32'h20, 32'h0, 32'h0);
    tick();
    tick();
    check("same_cycle_ack", v_t'({rsp_valid, rsp_rdata}), v_t'({1'b1, 32'hC0DE_0020}));
    wait_idle("idle_same");
    ack_delay = 1;

    // FIFO full while the regblock stalls
    cpuif_req_stall_rd = 1'b1;
    cpuif_req_stall_wr = 1'b1;
    exp_push(1'b0, 32'hC0DE_0040, 1'b0, 1'b0); send(1'b0, 32'h40, 32'h0, 32'h0);
    exp_push(1'b0, 32'hC0DE_0044, 1'b0, 1'b0); send(1'b0, 32'h44, 32'h0, 32'h0);
    exp_push(1'b1, 32'h0,         1'b0, 1'b0); send(1'b1, 32'h48, 32'h77, 32'hF0);
    exp_push(1'b0, 32'hC0DE_004C, 1'b0, 1'b0); send(1'b0, 32'h4C, 32'h0, 32'h0);
    exp_push(1'b0, 32'hC0DE_0050, 1'b0, 1'b0); send(1'b0, 32'h50, 32'h0, 32'h0);
    check("fifo_full_ready", v_t'(cmd_ready), v_t'(0));
    tick();
    check("fifo_full_hold", v_t'(cmd_ready), v_t'(0));
    cpuif_req_stall_rd = 1'b0;
    cpuif_req_stall_wr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) break;
      tick();
    end
    check("fifo_ready_back", v_t'(cmd_ready), v_t'(1));
    wait_idle("idle_fifo");

    // Timeout in WAIT_ACK, late acks ignored
    ack_mode = 0;
    rsp_ready = 1'b0;
    exp_push(1'b0, 32'h0, 1'b1, 1'b1);
    send(1'b0, 32'h60, 32'h0, 32'h0);
    tick();
    check("tmo_req", v_t'(cpuif_req), v_t'(1));
    repeat (7) tick();
    check("tmo_not_yet", v_t'(rsp_valid), v_t'(0));
    tick();
    check("tmo_fire", v_t'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cpuif_req}),
          v_t'({1'b1, 1'b1, 1'b1, 32'h0, 1'b0}));
    inject_req++;
    tick();
    tick();
    check("tmo_late_ack", v_t'({rsp_valid, rsp_is_wr, rsp_rdata, rsp_err, rsp_timeout}),
          v_t'({1'b1, 1'b0, 32'h0, 1'b1, 1'b1}));
    rsp_ready = 1'b1;
    wait_idle("idle_tmo");
    inject_req++;
    repeat (3) tick();
    check("idle_ack_ignored", v_t'({rsp_valid, busy}), v_t'(0));

    // Timeout while stalled in ISSUE
    cpuif_req_stall_wr = 1'b1;
    exp_push(1'b1, 32'h0, 1'b1, 1'b1);
    send(1'b1, 32'h64, 32'h9, 32'h1);
    wait_rsp("tmo_issue_seen");
    check("tmo_issue", v_t'({rsp_valid, cpuif_req, rsp_timeout}), v_t'(3'b101));
    cpuif_req_stall_wr = 1'b0;
    wait_idle("idle_tmo_issue");
    ack_mode = 1;

    // Response backpressure, then the one-cycle bubble
    rsp_ready = 1'b0;
    exp_push(1'b0, 32'hC0DE_0070, 1'b0, 1'b0);
    exp_push(1'b0, 32'hC0DE_0074, 1'b0, 1'b0);
    send(1'b0, 32'h70, 32'h0, 32'h0);
    send(1'b0, 32'h74, 32'h0, 32'h0);
    wait_rsp("bp_seen");
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", v_t'({rsp_valid, rsp_is_wr, rsp_rdata, rsp_err, rsp_timeout, cpuif_req}),
            v_t'({1'b1, 1'b0, 32'hC0DE_0070, 1'b0, 1'b0, 1'b0}));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bubble_idle", v_t'(cpuif_req), v_t'(0));
    tick();
    check("bubble_req", v_t'({cpuif_req, cpuif_addr}), v_t'({1'b1, 32'h74}));
    wait_idle("idle_bp");

    // Reset in WAIT_ACK with two commands queued
    ack_mode = 0;
    send(1'b0, 32'h80, 32'h0, 32'h0);
    send(1'b0, 32'h84, 32'h0, 32'h0);
    send(1'b0, 32'h88, 32'h0, 32'h0);
    check("mid_busy", v_t'({busy, cpuif_req}), v_t'(2'b10));
    #2;
    arst_n = 1'b0;
    #1;
    check("reset_async", all_outs(), v_t'(0));
    tick();
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_reset_quiet", v_t'({busy, rsp_valid, cpuif_req}), v_t'(0));
    end
    ack_mode = 1;
    exp_push(1'b0, 32'hC0DE_0090, 1'b0, 1'b0);
    send(1'b0, 32'h90, 32'h0, 32'h0);
    wait_idle("idle_after_reset");

    check("sb_empty", v_t'(sb.size()), v_t'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
